// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA output path.
//  - RGB565 colour constants used by the test-bar generator and for blanking.
//  - Default 1024x768@60 timing (65 MHz pixel clock).
//  - bar_colour(): maps a bar index 0..7 to its colour.
package vga_pkg;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFB80;
  localparam logic [15:0] YELLOW = 16'hFFC0;
  localparam logic [15:0] GREEN  = 16'h0400;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] INDIGO = 16'h4810;
  localparam logic [15:0] PURPLE = 16'h8010;
  localparam logic [15:0] WHITE  = 16'hFFDF;
  localparam logic [15:0] BLACK  = 16'h0000;

  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BACK   = 160;
  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FRONT  = 24;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BACK   = 29;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FRONT  = 3;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RED;
      3'd1:    c = ORANGE;
      3'd2:    c = YELLOW;
      3'd3:    c = GREEN;
      3'd4:    c = BLUE;
      3'd5:    c = INDIGO;
      3'd6:    c = PURPLE;
      default: c = WHITE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_testbar.sv
// vga_testbar: combinational colour-bar pattern, used only when VGA_TESTBAR_EN
// is defined. Splits the active line into 8 equal vertical bars.
// Ports:
//  addr_h  in   12  active column, 1-based (0 = outside the active area)
//  colour  out  16  RGB565 colour of the bar containing addr_h
module vga_testbar
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [11:0] addr_h,
  output logic [15:0] colour
);

  // A line narrower than 8 pixels still gets 1-pixel bars.
  localparam logic [11:0] BAR_W = 12'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

  logic [11:0] col;
  logic [11:0] idx;

  always_comb begin
    col    = (addr_h == 12'd0) ? 12'd0 : addr_h - 12'd1;
    idx    = col / BAR_W;
    // Leftover pixels when H_ACTIVE is not a multiple of 8 stay in the last bar.
    colour = (idx > 12'd7) ? WHITE : bar_colour(idx[2:0]);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator and pixel output stage.
//  Stage 1 registers the 1-based active coordinates (addr_h/addr_v) and frame_start
//  from the h/v counters; vga_control answers with rgb_in in that same cycle.
//  Stage 2 registers hs, vs, de and rgb to the pins so they share one alignment.
//  Optional feature macro: VGA_TESTBAR_EN replaces rgb_in with 8 colour bars.
// Ports:
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  rgb_in       in   16  RGB565 pixel for the current addr_h/addr_v
//  addr_h       out  12  active column 1..H_ACTIVE, 0 in blanking
//  addr_v       out  12  active row 1..V_ACTIVE, 0 in blanking
//  frame_start  out  1   1-clk pulse for counter position (0,0)
//  vga_hs       out  1   horizontal sync (asserted level = SYNC_POL)
//  vga_vs       out  1   vertical sync (asserted level = SYNC_POL)
//  vga_de       out  1   data enable
//  vga_rgb      out  16  RGB565 to the DAC, 0 when vga_de = 0
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rgb_in,
  output logic [11:0] addr_h,
  output logic [11:0] addr_v,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb
);

  localparam logic [11:0] H_TOT     = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
  localparam logic [11:0] V_TOT     = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
  localparam logic [11:0] H_SYN_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYN_END = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_END = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_ACT_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BACK + V_ACTIVE);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_act;
  logic        v_act;
  logic        act0;
  logic        act1;
  logic        hs1;
  logic        vs1;
  logic [15:0] pix;

  assign h_act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign act0  = h_act && v_act;

  // Raster counters: v_cnt advances only on the h_cnt wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_cnt == H_TOT - 12'd1) begin
      h_cnt <= 12'd0;
      v_cnt <= (v_cnt == V_TOT - 12'd1) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 1: coordinates for vga_control plus the sync/active flags that
  // travel alongside them, so stage 2 can line everything up with rgb_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_h      <= 12'd0;
      addr_v      <= 12'd0;
      frame_start <= 1'b0;
      act1        <= 1'b0;
      hs1         <= ~SYNC_POL;
      vs1         <= ~SYNC_POL;
    end else begin
      // Both coordinates are zero in blanking so vga_control never pops there.
      addr_h      <= act0 ? h_cnt - H_ACT_BEG + 12'd1 : 12'd0;
      addr_v      <= act0 ? v_cnt - V_ACT_BEG + 12'd1 : 12'd0;
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      act1        <= act0;
      hs1         <= (h_cnt < H_SYN_END) ? SYNC_POL : ~SYNC_POL;
      vs1         <= (v_cnt < V_SYN_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_TESTBAR_EN
  vga_testbar #(
    .H_ACTIVE(H_ACTIVE)
  ) u_testbar (
    .addr_h(addr_h),
    .colour(pix)
  );
`else
  assign pix = rgb_in;
`endif

  // Stage 2: pin registers. No stall path: an empty upstream FIFO just shows black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs  <= ~SYNC_POL;
      vga_vs  <= ~SYNC_POL;
      vga_de  <= 1'b0;
      vga_rgb <= BLACK;
    end else begin
      vga_hs  <= hs1;
      vga_vs  <= vs1;
      vga_de  <= act1;
      vga_rgb <= act1 ? pix : BLACK;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-mode (H 4/4/8/2, V 2/2/4/1) bench for vga_timing_gen.
// Hand-computed vector table for the first frame, then random rgb_in checked every
// cycle against a position-based reference model, then reset pulses mid-frame.
module tb_vga_timing_gen;

  localparam int HS = 4, HB = 4, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 4, VF = 1;
  localparam int H_TOT = HS + HB + HA + HF;   // 18
  localparam int V_TOT = VS + VB + VA + VF;   // 9
  localparam int F_TOT = H_TOT * V_TOT;       // 162

`ifdef VGA_TESTBAR_EN
  localparam logic [15:0] PIX1 = 16'hF800;
  localparam logic [15:0] PIX7 = 16'h8010;
  localparam logic [15:0] PIX8 = 16'hFFDF;
`else
  localparam logic [15:0] PIX1 = 16'hA5A5;
  localparam logic [15:0] PIX7 = 16'hA5A5;
  localparam logic [15:0] PIX8 = 16'hA5A5;
`endif

  logic [15:0] bar_tab [8] = '{16'hF800, 16'hFB80, 16'hFFC0, 16'h0400,
                               16'h001F, 16'h4810, 16'h8010, 16'hFFDF};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rgb_in = 16'h0;
  logic [11:0] addr_h, addr_v;
  logic        frame_start, vga_hs, vga_vs, vga_de;
  logic [15:0] vga_rgb;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rgb_in(rgb_in),
    .addr_h(addr_h),
    .addr_v(addr_v),
    .frame_start(frame_start),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_de(vga_de),
    .vga_rgb(vga_rgb)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  int n = 0;                 // posedges since last reset release
  logic [15:0] exp_q [$];    // rgb_in values waiting to reach the pins

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @n=%0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit in_active(input int h, input int v);
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  function automatic logic [15:0] pixel(input int h, input logic [15:0] rgb);
`ifdef VGA_TESTBAR_EN
    return bar_tab[(h - HS - HB) / (HA / 8)];
`else
    return rgb;
`endif
  endfunction

  // Reference model: after posedge n, stage 1 shows raster position n-1 and the
  // pins show position n-2 (pins still hold reset values after posedge 1).
  task automatic check_cycle(input int cyc, input logic [15:0] rgb_seen);
    int p1, p2, h, v;
    bit a;
    p1 = (cyc - 1) % F_TOT;
    h  = p1 % H_TOT;
    v  = p1 / H_TOT;
    a  = in_active(h, v);
    chk("frame_start", cyc, frame_start, (p1 == 0));
    chk("addr_h", cyc, addr_h, a ? h - HS - HB + 1 : 0);
    chk("addr_v", cyc, addr_v, a ? v - VS - VB + 1 : 0);
    if (cyc == 1) begin
      chk("hs", cyc, vga_hs, 1);
      chk("vs", cyc, vga_vs, 1);
      chk("de", cyc, vga_de, 0);
      chk("rgb", cyc, vga_rgb, 0);
    end else begin
      p2 = (cyc - 2) % F_TOT;
      h  = p2 % H_TOT;
      v  = p2 / H_TOT;
      a  = in_active(h, v);
      chk("hs", cyc, vga_hs, (h >= HS));
      chk("vs", cyc, vga_vs, (v >= VS));
      chk("de", cyc, vga_de, a);
      chk("rgb", cyc, vga_rgb, a ? pixel(h, rgb_seen) : 16'h0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fs"}, n, frame_start, 0);
    chk({tag, "_addr_h"}, n, addr_h, 0);
    chk({tag, "_addr_v"}, n, addr_v, 0);
    chk({tag, "_hs"}, n, vga_hs, 1);
    chk({tag, "_vs"}, n, vga_vs, 1);
    chk({tag, "_de"}, n, vga_de, 0);
    chk({tag, "_rgb"}, n, vga_rgb, 0);
  endtask

  // Driver: one clock step with model check and a fresh random pixel.
  task automatic step_random();
    logic [15:0] r;
    @(posedge clk);
    n++;
    @(negedge clk);
    check_cycle(n, exp_q.pop_front());
    r = 16'($urandom);
    if ($urandom_range(0, 7) == 0) r = 16'h0;   // upstream FIFO empty
    rgb_in = r;
    exp_q.push_back(r);
  endtask

  task automatic release_reset();
    rgb_in = 16'($urandom);
    exp_q.delete();
    exp_q.push_back(rgb_in);
    rst_n = 1'b1;
    n = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic        fs;
    logic [11:0] ah;
    logic [11:0] av;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int first_fs, second_fs;

    vecs[0]  = '{1,   1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 16'h0};
    vecs[1]  = '{2,   1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[2]  = '{5,   1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[3]  = '{6,   1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    vecs[4]  = '{37,  1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    vecs[5]  = '{38,  1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[6]  = '{81,  1'b0, 12'd1, 12'd1, 1'b1, 1'b1, 1'b0, 16'h0};
    vecs[7]  = '{82,  1'b0, 12'd2, 12'd1, 1'b1, 1'b1, 1'b1, PIX1};
    vecs[8]  = '{88,  1'b0, 12'd8, 12'd1, 1'b1, 1'b1, 1'b1, PIX7};
    vecs[9]  = '{89,  1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, PIX8};
    vecs[10] = '{90,  1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 16'h0};
    vecs[11] = '{142, 1'b0, 12'd8, 12'd4, 1'b1, 1'b1, 1'b1, PIX7};
    vecs[12] = '{163, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 16'h0};
    vecs[13] = '{164, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 16'h0};

    // Reset held 10 clocks.
    rst_n  = 1'b0;
    rgb_in = 16'hA5A5;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    n = 0;

    // First frame with constant rgb_in against the hand-computed table.
    for (int i = 0; i < 14; i++) begin
      while (n < vecs[i].n) begin
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      chk("tab_fs", n, frame_start, vecs[i].fs);
      chk("tab_addr_h", n, addr_h, vecs[i].ah);
      chk("tab_addr_v", n, addr_v, vecs[i].av);
      chk("tab_hs", n, vga_hs, vecs[i].hs);
      chk("tab_vs", n, vga_vs, vecs[i].vs);
      chk("tab_de", n, vga_de, vecs[i].de);
      chk("tab_rgb", n, vga_rgb, vecs[i].rgb);
    end

    // Random pixels for about two more frames, up to counter position h=10, v=3.
    exp_q.push_back(16'hA5A5);
    while (n < 550) step_random();

    // Mid-frame reset at h_cnt=10, v_cnt=3: outputs go to reset values without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("held_rst");
    release_reset();

    // Frame_start right after release, then one frame period later.
    first_fs  = -1;
    second_fs = -1;
    while (n < 170) begin
      step_random();
      if (frame_start === 1'b1) begin
        if (first_fs < 0) first_fs = n;
        else if (second_fs < 0) second_fs = n;
      end
    end
    chk("first_fs_after_reset", n, first_fs, 1);
    chk("fs_period", n, second_fs - first_fs, F_TOT);

    // Reset while a pixel is on the pins.
    while (n % F_TOT != 84) step_random();
    chk("pre_rst_de", n, vga_de, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("active_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    release_reset();
    repeat (20) step_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
